ifft_frame_addr_counter: RTL and testbench
==========================================

// Module: ifft_frame_addr_counter
// PURPOSE
//  Parametrised address/stage sequencer for the N-point IFFT core; successor to the 4-bit free-running counter.
//  Emits natural and bit-reversed sample index plus butterfly stage index, framed by a start/busy/done handshake.
//  Sits between the NB-IoT TX control FSM and the IFFT memory/butterfly datapath; supports single-shot and continuous frames.
// PARAMETERS
//  N_POINTS   16               IFFT size; power of two, 4..2048
//  ADDR_W     $clog2(N_POINTS) sample-index width (derived, do not override)
//  NUM_STAGES ADDR_W           radix-2 stages per frame
//  STAGE_W    $clog2(NUM_STAGES) stage-index width; minimum 1
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        synchronous reset, active-low
//  start       in   1        begin frame; sampled only in IDLE
//  enable      in   1        advance one count this cycle; low = hold all state
//  abort       in   1        synchronous return to IDLE, no done pulse
//  cont_mode   in   1        1 = re-arm automatically after last count of a frame
//  busy        out  1        high while in RUN
//  idx         out  ADDR_W   natural sample index
//  idx_rev     out  ADDR_W   bit-reversed idx (combinational from idx)
//  stage       out  STAGE_W  current butterfly stage
//  stage_last  out  1        combinational: busy && idx==N_POINTS-1
//  frame_done  out  1        registered one-cycle pulse after final count of frame
// BEHAVIOUR
//  - rst low at a clk edge: state=IDLE, idx=0, stage=0, busy=0, frame_done=0; reset overrides start/abort/enable.
//  - FSM: IDLE --start--> RUN (next cycle busy=1, idx=0, stage=0). start while busy is ignored.
//  - RUN, enable=1: idx<=idx+1 (mod N_POINTS). When idx==N_POINTS-1: idx<=0, stage<=stage+1.
//  - Final count = enable && idx==N_POINTS-1 && stage==NUM_STAGES-1: next cycle frame_done=1, idx=0, stage=0;
//    cont_mode=1 -> stay RUN (busy stays 1, no gap cycle); cont_mode=0 -> IDLE (busy=0 same cycle as frame_done).
//  - cont_mode sampled at the final-count edge only; changes mid-frame have no effect until then.
//  - enable=0 in RUN: idx, stage, state held; stage_last still reflects held idx.
//  - enable ignored in IDLE; idx/stage stay 0.
//  - abort=1 (any state, rst high): next cycle IDLE, idx=0, stage=0, frame_done=0; abort beats final count and start.
//  - frame_done is never high for two consecutive cycles unless continuous frames each complete (min spacing N_POINTS*NUM_STAGES cycles).
//  - Latency: start -> first valid idx 1 cycle; frame length exactly N_POINTS*NUM_STAGES enabled cycles.
//  - No arithmetic overflow: idx and stage wrap by explicit compare, never rely on natural width wrap for stage.
// STRUCTURE
//  - Shared package ifft_ctrl_pkg: N_POINTS default, clog2-derived widths, state encoding (IDLE=1'b0, RUN=1'b1),
//    and function bit_rev(idx) used by this block and the IFFT memory address mux.
//  - No sub-module; single always block for FSM + counters, continuous assigns for idx_rev and stage_last.
// TESTING
//  1. rst low 2 cycles with start=1,enable=1 -> busy=0, idx=0, stage=0, frame_done=0 throughout.
//  2. N_POINTS=16, start then enable=1 for 64 cycles -> idx 0..15 x4, stage 0..3, idx_rev(1)=8, idx_rev(3)=12; frame_done 1 cycle after 64th count, busy falls with it.
//  3. cont_mode=1, enable held high 128 cycles -> two frame_done pulses 64 cycles apart, busy never drops, idx 15->0 seamless.
//  4. enable toggled 1/0 every cycle in RUN -> frame completes after 128 cycles; held values stable on enable=0 cycles.
//  5. abort asserted on final-count cycle (idx=15, stage=3) -> no frame_done, IDLE, idx=0; start re-accepted next cycle.
//  6. start pulsed mid-frame at idx=7, stage=1 -> no effect; sync rst low mid-frame -> all outputs 0 next edge.

Source files
------------

// File: rtl/ifft_ctrl_pkg.sv
// Shared IFFT control definitions: default size, FSM encoding and the
// bit-reversal helper used by the address counter and the memory address mux.
package ifft_ctrl_pkg;

  localparam int N_POINTS_DEF = 16;
  // Largest supported transform is 2048 points.
  localparam int MAX_ADDR_W   = 11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Reverses the low 'width' bits of idx; bits at and above 'width' return 0.
  function automatic logic [MAX_ADDR_W-1:0] bit_rev(
    input logic [MAX_ADDR_W-1:0] idx,
    input int                    width
  );
    logic [MAX_ADDR_W-1:0] rev;
    rev = '0;
    for (int i = 0; i < MAX_ADDR_W; i++) begin
      if (i < width) rev[i] = idx[width-1-i];
    end
    return rev;
  endfunction

endpackage

// File: rtl/ifft_frame_addr_counter.sv
// Address/stage sequencer for the N-point radix-2 IFFT: natural and bit-reversed
// sample index plus stage index, framed by start/busy/frame_done; 1-cycle start latency.
module ifft_frame_addr_counter
  import ifft_ctrl_pkg::*;
#(
  parameter  int N_POINTS   = N_POINTS_DEF,
  localparam int ADDR_W     = $clog2(N_POINTS),
  localparam int NUM_STAGES = ADDR_W,
  localparam int STAGE_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               enable,
  input  logic               abort,
  input  logic               cont_mode,
  output logic               busy,
  output logic [ADDR_W-1:0]  idx,
  output logic [ADDR_W-1:0]  idx_rev,
  output logic [STAGE_W-1:0] stage,
  output logic               stage_last,
  output logic               frame_done
);

  localparam logic [ADDR_W-1:0]  IDX_MAX   = ADDR_W'(N_POINTS - 1);
  localparam logic [STAGE_W-1:0] STAGE_MAX = STAGE_W'(NUM_STAGES - 1);

  state_t               r_state;
  logic [ADDR_W-1:0]    r_idx;
  logic [STAGE_W-1:0]   r_stage;
  logic                 r_done;

  state_t               w_state_nxt;
  logic [ADDR_W-1:0]    w_idx_nxt;
  logic [STAGE_W-1:0]   w_stage_nxt;
  logic                 w_done_nxt;
  logic                 w_idx_at_max;
  logic                 w_stage_at_max;

  assign w_idx_at_max   = (r_idx == IDX_MAX);
  assign w_stage_at_max = (r_stage == STAGE_MAX);

  // All FSM and counter state lives in this one register process.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_stage <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_stage <= w_stage_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_stage_nxt = r_stage;
    w_done_nxt  = 1'b0;

    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
      w_stage_nxt = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_idx_nxt   = '0;
          w_stage_nxt = '0;
          if (start) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (enable) begin
            if (w_idx_at_max) begin
              w_idx_nxt = '0;
              // Explicit wrap keeps non-power-of-two stage counts correct.
              if (w_stage_at_max) begin
                w_stage_nxt = '0;
                w_done_nxt  = 1'b1;
                w_state_nxt = cont_mode ? ST_RUN : ST_IDLE;
              end else begin
                w_stage_nxt = r_stage + STAGE_W'(1);
              end
            end else begin
              w_idx_nxt = r_idx + ADDR_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
          w_stage_nxt = '0;
        end
      endcase
    end
  end

  always_comb begin
    busy       = (r_state == ST_RUN);
    idx        = r_idx;
    stage      = r_stage;
    frame_done = r_done;
    stage_last = busy && w_idx_at_max;
    idx_rev    = ADDR_W'(bit_rev(MAX_ADDR_W'(r_idx), ADDR_W));
  end

endmodule

// File: tb/tb_ifft_frame_addr_counter.sv
// Directed bench for the 16-point IFFT address/stage sequencer.
module tb_ifft_frame_addr_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       enable = 1'b0;
  logic       abort = 1'b0;
  logic       cont_mode = 1'b0;
  logic       busy;
  logic [3:0] idx;
  logic [3:0] idx_rev;
  logic [1:0] stage;
  logic       stage_last;
  logic       frame_done;

  int n_total  = 0;
  int n_passed = 0;

  ifft_frame_addr_counter #(.N_POINTS(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .enable     (enable),
    .abort      (abort),
    .cont_mode  (cont_mode),
    .busy       (busy),
    .idx        (idx),
    .idx_rev    (idx_rev),
    .stage      (stage),
    .stage_last (stage_last),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst_n, st, en, ab, cm;
    int   busy, idx, stage, sl, fd, rev;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rev4(input int v);
    logic [3:0] r;
    r = {v[0], v[1], v[2], v[3]};
    return int'(r);
  endfunction

  task automatic chk_all(input string tag, input int e_busy, input int e_idx,
                         input int e_stage, input int e_sl, input int e_fd);
    chk({tag, " busy"},       int'(busy),       e_busy);
    chk({tag, " idx"},        int'(idx),        e_idx);
    chk({tag, " stage"},      int'(stage),      e_stage);
    chk({tag, " stage_last"}, int'(stage_last), e_sl);
    chk({tag, " frame_done"}, int'(frame_done), e_fd);
    chk({tag, " idx_rev"},    int'(idx_rev),    rev4(e_idx));
  endtask

  initial begin
    int cnt;
    int pulses;
    bit done_seen;

    //          rst st en ab cm   busy idx stg sl fd rev
    vecs[0]  = '{0, 1, 1, 0, 0,   0,   0,  0,  0, 0, 0};
    vecs[1]  = '{0, 1, 1, 0, 0,   0,   0,  0,  0, 0, 0};
    vecs[2]  = '{1, 0, 1, 0, 0,   0,   0,  0,  0, 0, 0};
    vecs[3]  = '{1, 1, 0, 0, 0,   1,   0,  0,  0, 0, 0};
    vecs[4]  = '{1, 0, 1, 0, 0,   1,   1,  0,  0, 0, 8};
    vecs[5]  = '{1, 0, 0, 0, 0,   1,   1,  0,  0, 0, 8};
    vecs[6]  = '{1, 0, 1, 0, 0,   1,   2,  0,  0, 0, 4};
    vecs[7]  = '{1, 0, 1, 0, 0,   1,   3,  0,  0, 0, 12};
    vecs[8]  = '{1, 1, 1, 0, 0,   1,   4,  0,  0, 0, 2};
    vecs[9]  = '{1, 0, 1, 1, 0,   0,   0,  0,  0, 0, 0};
    vecs[10] = '{1, 1, 0, 1, 0,   0,   0,  0,  0, 0, 0};
    vecs[11] = '{1, 1, 0, 0, 0,   1,   0,  0,  0, 0, 0};
    vecs[12] = '{0, 0, 1, 0, 0,   0,   0,  0,  0, 0, 0};
    vecs[13] = '{1, 0, 1, 0, 0,   0,   0,  0,  0, 0, 0};

    #1;
    for (int v = 0; v < 14; v++) begin
      rst = vecs[v].rst_n; start = vecs[v].st; enable = vecs[v].en;
      abort = vecs[v].ab; cont_mode = vecs[v].cm;
      tick();
      chk($sformatf("vec%0d busy", v),       int'(busy),       vecs[v].busy);
      chk($sformatf("vec%0d idx", v),        int'(idx),        vecs[v].idx);
      chk($sformatf("vec%0d stage", v),      int'(stage),      vecs[v].stage);
      chk($sformatf("vec%0d stage_last", v), int'(stage_last), vecs[v].sl);
      chk($sformatf("vec%0d frame_done", v), int'(frame_done), vecs[v].fd);
      chk($sformatf("vec%0d idx_rev", v),    int'(idx_rev),    vecs[v].rev);
    end

    // Single-shot frame: 64 enabled counts, done pulse as busy falls.
    start = 1'b1; enable = 1'b0; cont_mode = 1'b0; abort = 1'b0;
    tick();
    start = 1'b0; enable = 1'b1;
    for (int k = 0; k < 64; k++) begin
      chk_all($sformatf("single k%0d", k), 1, k % 16, k / 16, (k % 16 == 15) ? 1 : 0, 0);
      tick();
    end
    chk_all("single end", 0, 0, 0, 0, 1);
    tick();
    chk_all("single after", 0, 0, 0, 0, 0);

    // Continuous frames; cont_mode dropped mid second frame takes effect at its end.
    cont_mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    for (int j = 1; j <= 128; j++) begin
      if (j == 70) cont_mode = 1'b0;
      tick();
      chk($sformatf("cont j%0d frame_done", j), int'(frame_done), (j % 64 == 0) ? 1 : 0);
      chk($sformatf("cont j%0d busy", j),       int'(busy),       (j == 128) ? 0 : 1);
      chk($sformatf("cont j%0d idx", j),        int'(idx),        j % 16);
      chk($sformatf("cont j%0d stage", j),      int'(stage),      (j / 16) % 4);
      if (frame_done) pulses++;
    end
    chk("cont pulses", pulses, 2);

    // Enable toggling: frame needs 128 cycles, values hold on idle cycles.
    start = 1'b1; enable = 1'b0;
    tick();
    start = 1'b0;
    cnt = 0;
    done_seen = 1'b0;
    for (int c = 0; c < 128 && !done_seen; c++) begin
      enable = (c % 2 == 0);
      tick();
      if (enable) cnt++;
      if (cnt == 64) begin
        chk_all($sformatf("toggle c%0d", c), 0, 0, 0, 0, 1);
        chk("toggle cycle of done", c, 126);
        done_seen = 1'b1;
      end else begin
        chk_all($sformatf("toggle c%0d", c), 1, cnt % 16, cnt / 16,
                (cnt % 16 == 15) ? 1 : 0, 0);
      end
    end
    chk("toggle done seen", int'(done_seen), 1);

    // Abort on the final-count cycle suppresses frame_done.
    enable = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; enable = 1'b1;
    for (int k = 0; k < 63; k++) tick();
    chk_all("pre-abort", 1, 15, 3, 1, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0; enable = 1'b0;
    chk_all("abort", 0, 0, 0, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("restart", 1, 0, 0, 0, 0);

    // start mid-frame is ignored; reset mid-frame clears everything.
    enable = 1'b1;
    for (int k = 0; k < 23; k++) tick();
    chk_all("mid", 1, 7, 1, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("mid start", 1, 8, 1, 0, 0);
    rst = 1'b0;
    tick();
    chk_all("mid reset", 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    chk_all("post reset", 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
